dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_sram_array.sv | 31 +++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Wait counter width; covers LATENCY up to 15.
    localparam int unsigned CNT_W  = 4;
    // Width of one byte lane.
    localparam int unsigned LANE_W = 8;

    // Partial-word write whose enable pattern does not match the address alignment.
    function automatic logic misaligned(input logic [3:0] be, input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (be)
            4'b1111:          r = (addr_lo != 2'b00);
            4'b0011, 4'b1100: r = addr_lo[0];
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus. dmem_err exists only when DMEM_RESP_ERR_EN is defined.
interface dmem_responder_if;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
`ifdef DMEM_RESP_ERR_EN
    logic        dmem_err;

    modport master (
        output dmem_address, dmem_read, dmem_write, mem_byte_enable, dmem_wdata,
        input  dmem_rdata, dmem_resp, dmem_err
    );
    modport slave (
        input  dmem_address, dmem_read, dmem_write, mem_byte_enable, dmem_wdata,
        output dmem_rdata, dmem_resp, dmem_err
    );
`else
    modport master (
        output dmem_address, dmem_read, dmem_write, mem_byte_enable, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );
    modport slave (
        input  dmem_address, dmem_read, dmem_write, mem_byte_enable, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
`endif
endinterface

// File: rtl/dmem_sram_array.sv
// Word-addressed storage: synchronous byte-lane write, asynchronous read. Never reset.
module dmem_sram_array
    import dmem_pkg::*;
#(
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [31:0] r_mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    r_mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdata = r_mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder. Optional error reporting under DMEM_RESP_ERR_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned IDX_W   = 10
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic             r_write;
    logic             r_resp;
    logic [31:0]      r_rdata;

    logic             w_req;
    logic             w_to_resp;
    logic             w_is_write;
    logic             w_we;
    logic [IDX_W-1:0] w_in_idx;
    logic [IDX_W-1:0] w_sram_idx;
    logic [31:0]      w_mem_rdata;

    assign w_req    = bus.dmem_read | bus.dmem_write;
    assign w_in_idx = bus.dmem_address[IDX_W+1:2];

    // Read side of the array must see the live address on the IDLE->RESP path (LATENCY=1),
    // where the index has not been latched yet.
    assign w_sram_idx = (r_state == IDLE) ? w_in_idx : r_idx;
    assign w_is_write = (r_state == IDLE) ? bus.dmem_write : r_write;

    // Decide whether the next cycle is the RESP cycle.
    always_comb begin
        w_to_resp = 1'b0;
        unique case (r_state)
            IDLE:    w_to_resp = w_req && (CNT_LOAD == '0);
            WAIT:    w_to_resp = (r_cnt <= CNT_W'(1));
            default: w_to_resp = 1'b0;
        endcase
    end

`ifdef DMEM_RESP_ERR_EN
    logic w_err_in;
    logic r_err_req;
    logic r_err;

    assign w_err_in = (bus.dmem_address[31:IDX_W+2] != '0)
                    | (bus.dmem_read & bus.dmem_write)
                    | (bus.dmem_write & misaligned(bus.mem_byte_enable, bus.dmem_address[1:0]));
    // An erroring write leaves storage untouched.
    assign w_we       = (r_state == RESP) && r_write && !r_err_req;
    assign bus.dmem_err = r_err;
`else
    logic w_unused;

    assign w_unused = ^{bus.dmem_address[31:IDX_W+2], bus.dmem_address[1:0]};
    assign w_we     = (r_state == RESP) && r_write;
`endif

    // FSM, request latches and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_write   <= 1'b0;
            r_resp    <= 1'b0;
            r_rdata   <= '0;
`ifdef DMEM_RESP_ERR_EN
            r_err_req <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_resp  <= w_to_resp;
            // Writes (including read+write) return zero data.
            r_rdata <= (w_to_resp && !w_is_write) ? w_mem_rdata : '0;
`ifdef DMEM_RESP_ERR_EN
            r_err   <= w_to_resp && ((r_state == IDLE) ? w_err_in : r_err_req);
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx   <= w_in_idx;
                        r_wdata <= bus.dmem_wdata;
                        r_be    <= bus.mem_byte_enable;
                        r_write <= bus.dmem_write;
                        r_cnt   <= CNT_LOAD;
`ifdef DMEM_RESP_ERR_EN
                        r_err_req <= w_err_in;
`endif
                        r_state <= (CNT_LOAD == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    dmem_sram_array #(
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (w_we),
        .be    (r_be),
        .idx   (w_sram_idx),
        .wdata (r_wdata),
        .rdata (w_mem_rdata)
    );

    assign bus.dmem_resp  = r_resp;
    assign bus.dmem_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 1, 2, 3) sharing stimulus, selected by sel.
module tb_dmem_responder;

    logic        clk;
    logic [2:0]  rstn;
    int          sel;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic        b_rd;
    logic        b_wr;

    logic        o_resp;
    logic [31:0] o_rdata;
    logic        o_err;

    int n_checks;
    int n_errors;

    dmem_responder_if if_l1 ();
    dmem_responder_if if_l2 ();
    dmem_responder_if if_l3 ();

    assign if_l1.dmem_address    = b_addr;
    assign if_l1.dmem_wdata      = b_wdata;
    assign if_l1.mem_byte_enable = b_be;
    assign if_l1.dmem_read       = b_rd && (sel == 0);
    assign if_l1.dmem_write      = b_wr && (sel == 0);
    assign if_l2.dmem_address    = b_addr;
    assign if_l2.dmem_wdata      = b_wdata;
    assign if_l2.mem_byte_enable = b_be;
    assign if_l2.dmem_read       = b_rd && (sel == 1);
    assign if_l2.dmem_write      = b_wr && (sel == 1);
    assign if_l3.dmem_address    = b_addr;
    assign if_l3.dmem_wdata      = b_wdata;
    assign if_l3.mem_byte_enable = b_be;
    assign if_l3.dmem_read       = b_rd && (sel == 2);
    assign if_l3.dmem_write      = b_wr && (sel == 2);

    dmem_responder #(.LATENCY(1), .IDX_W(10)) u_dut_l1 (.clk(clk), .rst(rstn[0]), .bus(if_l1));
    dmem_responder #(.LATENCY(2), .IDX_W(10)) u_dut_l2 (.clk(clk), .rst(rstn[1]), .bus(if_l2));
    dmem_responder #(.LATENCY(3), .IDX_W(10)) u_dut_l3 (.clk(clk), .rst(rstn[2]), .bus(if_l3));

    always_comb begin
        o_resp  = 1'b0;
        o_rdata = '0;
        o_err   = 1'b0;
        case (sel)
            0: begin o_resp = if_l1.dmem_resp; o_rdata = if_l1.dmem_rdata; end
            1: begin o_resp = if_l2.dmem_resp; o_rdata = if_l2.dmem_rdata; end
            default: begin o_resp = if_l3.dmem_resp; o_rdata = if_l3.dmem_rdata; end
        endcase
`ifdef DMEM_RESP_ERR_EN
        case (sel)
            0:       o_err = if_l1.dmem_err;
            1:       o_err = if_l2.dmem_err;
            default: o_err = if_l3.dmem_err;
        endcase
`endif
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance s, hold it until dmem_resp, then drop it.
    task automatic do_req(input int s, input logic wr, input logic rd, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input int lat,
                          output logic [31:0] rdata, output logic err);
        int  n;
        bit  got;
        n     = 0;
        got   = 0;
        rdata = '0;
        err   = 1'b0;
        sel   = s;
        b_addr  = a;
        b_be    = be;
        b_wdata = wd;
        b_wr    = wr;
        b_rd    = rd;
        while (!got && n < 20) begin
            step();
            n++;
            if (o_resp === 1'b1) begin
                got   = 1;
                rdata = o_rdata;
                err   = o_err;
            end else begin
                check_eq("rdata_zero_wait", o_rdata, 32'h0);
            end
        end
        b_rd = 1'b0;
        b_wr = 1'b0;
        check_eq("resp_seen", 32'(got), 32'd1);
        check_eq("latency", 32'(n), 32'(lat));
        step();
        check_eq("resp_one_cycle", 32'(o_resp), 32'd0);
        check_eq("rdata_zero_after", o_rdata, 32'h0);
    endtask

    logic [31:0] rd_val;
    logic        err_val;

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel      = 0;
        b_addr   = '0;
        b_wdata  = '0;
        b_be     = '0;
        b_rd     = 1'b0;
        b_wr     = 1'b0;
        rstn     = 3'b000;

        // Reset state on all three instances.
        repeat (3) step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check_eq("rst_resp", 32'(o_resp), 32'd0);
            check_eq("rst_rdata", o_rdata, 32'h0);
        end
        rstn = 3'b111;
        step();

        // Read 0x10, LATENCY=2: response exactly at T+2, zero data elsewhere.
        do_req(1, 1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h0, 2, rd_val, err_val);

        // Full-word write then read back.
        do_req(1, 1'b1, 1'b0, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 2, rd_val, err_val);
        check_eq("wr_rdata_zero", rd_val, 32'h0);
        do_req(1, 1'b0, 1'b1, 32'h0000_0040, 4'b0000, 32'h0, 2, rd_val, err_val);
        check_eq("rd_deadbeef", rd_val, 32'hDEAD_BEEF);

        // Single-lane write of 0xAA to byte 2 (lane-aligned data).
        do_req(1, 1'b1, 1'b0, 32'h0000_0042, 4'b0100, 32'h00AA_0000, 2, rd_val, err_val);
        do_req(1, 1'b0, 1'b1, 32'h0000_0040, 4'b1111, 32'h0, 2, rd_val, err_val);
        check_eq("rd_lane2", rd_val, 32'hDEAA_BEEF);

        // Zero byte enable: responds, no update.
        do_req(1, 1'b1, 1'b0, 32'h0000_0040, 4'b0000, 32'hFFFF_FFFF, 2, rd_val, err_val);
        do_req(1, 1'b0, 1'b1, 32'h0000_0040, 4'b1111, 32'h0, 2, rd_val, err_val);
        check_eq("rd_be0_noupdate", rd_val, 32'hDEAA_BEEF);

`ifndef DMEM_RESP_ERR_EN
        // Aliasing modulo 2^IDX_W words.
        do_req(1, 1'b0, 1'b1, 32'h0000_1040, 4'b1111, 32'h0, 2, rd_val, err_val);
        check_eq("rd_alias", rd_val, 32'hDEAA_BEEF);
`endif

        // Read+write together acts as a write with zero read data.
        do_req(1, 1'b1, 1'b1, 32'h0000_0044, 4'b1111, 32'h0BAD_F00D, 2, rd_val, err_val);
        check_eq("rdwr_rdata_zero", rd_val, 32'h0);
        do_req(1, 1'b0, 1'b1, 32'h0000_0044, 4'b1111, 32'h0, 2, rd_val, err_val);
`ifdef DMEM_RESP_ERR_EN
        check_eq("rdwr_err_noupdate_diff", 32'(rd_val != 32'h0BAD_F00D), 32'd1);
`else
        check_eq("rdwr_written", rd_val, 32'h0BAD_F00D);
`endif

        // LATENCY=1, read held for 10 cycles: pulses at T+1,3,5,7,9.
        do_req(0, 1'b1, 1'b0, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 1, rd_val, err_val);
        sel    = 0;
        b_addr = 32'h0000_0008;
        b_rd   = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_eq($sformatf("held_resp_%0d", k), 32'(o_resp), 32'(k % 2));
            check_eq($sformatf("held_rdata_%0d", k), o_rdata,
                     (k % 2 == 1) ? 32'hCAFE_F00D : 32'h0);
            if (k == 9) b_rd = 1'b0;
        end

        // Asynchronous reset during a RESP cycle clears outputs at once.
        b_rd = 1'b1;
        step();
        b_rd = 1'b0;
        check_eq("pre_rst_resp", 32'(o_resp), 32'd1);
        rstn[0] = 1'b0;
        #1;
        check_eq("async_rst_resp", 32'(o_resp), 32'd0);
        check_eq("async_rst_rdata", o_rdata, 32'h0);
        step();
        rstn[0] = 1'b1;
        step();

        // LATENCY=3: reset in T+1 drops the pending write, no response.
        do_req(2, 1'b1, 1'b0, 32'h0000_0080, 4'b1111, 32'h1111_1111, 3, rd_val, err_val);
        sel     = 2;
        b_addr  = 32'h0000_0080;
        b_wdata = 32'h1234_5678;
        b_be    = 4'b1111;
        b_wr    = 1'b1;
        step();
        rstn[2] = 1'b0;
        b_wr    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("rst_drop_resp", 32'(o_resp), 32'd0);
            step();
        end
        rstn[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("post_rst_resp", 32'(o_resp), 32'd0);
        end
        do_req(2, 1'b0, 1'b1, 32'h0000_0080, 4'b1111, 32'h0, 3, rd_val, err_val);
        check_eq("rd_old_after_rst", rd_val, 32'h1111_1111);

        // Out-of-range write to 0x1000: error with the macro, alias to word 0 without.
        do_req(1, 1'b1, 1'b0, 32'h0000_0000, 4'b1111, 32'h5A5A_5A5A, 2, rd_val, err_val);
        do_req(1, 1'b1, 1'b0, 32'h0000_1000, 4'b1111, 32'h0000_0001, 2, rd_val, err_val);
`ifdef DMEM_RESP_ERR_EN
        check_eq("oor_err", 32'(err_val), 32'd1);
        do_req(1, 1'b0, 1'b1, 32'h0000_0000, 4'b1111, 32'h0, 2, rd_val, err_val);
        check_eq("oor_word0_kept", rd_val, 32'h5A5A_5A5A);
        check_eq("inrange_no_err", 32'(err_val), 32'd0);
`else
        do_req(1, 1'b0, 1'b1, 32'h0000_0000, 4'b1111, 32'h0, 2, rd_val, err_val);
        check_eq("oor_word0_alias", rd_val, 32'h0000_0001);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
